// File: rtl/axi_write_responder.sv
// AXI4 write responder: accepts INCR bursts over AW/W, stores them in a word RAM, answers on B.
// Optional macro AXI_WR_RESP_RANGE_CHECK_EN: out-of-range bursts are absorbed unwritten and answered SLVERR.
module axi_write_responder #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                    AXI_ACLK,
  input  logic                    AXI_ARESET,
  input  logic                    AXI_AWVALID,
  output logic                    AXI_AWREADY,
  input  logic [ID_WIDTH-1:0]     AXI_AWID,
  input  logic [ADDR_WIDTH-1:0]   AXI_AWADDR,
  input  logic [7:0]              AXI_AWLEN,
  input  logic                    AXI_WVALID,
  output logic                    AXI_WREADY,
  input  logic [DATA_WIDTH-1:0]   AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] AXI_WSTRB,
  input  logic                    AXI_WLAST,
  output logic                    AXI_BVALID,
  input  logic                    AXI_BREADY,
  output logic [ID_WIDTH-1:0]     AXI_BID,
  output logic [1:0]              AXI_BRESP,
  input  logic [DEPTH_LOG2-1:0]   MEM_RADDR,
  output logic [DATA_WIDTH-1:0]   MEM_RDATA
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned OFFS  = $clog2(BYTES);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_e;

  state_e                  state_q, state_d;
  logic                    awready_q, awready_d;
  logic                    wready_q, wready_d;
  logic                    bvalid_q, bvalid_d;
  logic [ID_WIDTH-1:0]     bid_q, bid_d;
  logic [1:0]              bresp_q, bresp_d;
  logic [DEPTH_LOG2-1:0]   ptr_q, ptr_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    we_c;
  logic [DEPTH_LOG2-1:0]   aw_word_c;
  logic                    addr_unused_c;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  assign aw_word_c     = AXI_AWADDR[OFFS+DEPTH_LOG2-1:OFFS];
  assign addr_unused_c = ^AXI_AWADDR;

`ifdef AXI_WR_RESP_RANGE_CHECK_EN
  localparam int unsigned SUM_W = DEPTH_LOG2 + 9;
  logic drop_q, drop_d;
  logic rng_err_c;
  // Reject stray upper address bits and bursts that would run past the last word.
  assign rng_err_c = ((AXI_AWADDR >> (OFFS + DEPTH_LOG2)) != '0) ||
                     ((SUM_W'(aw_word_c) + SUM_W'(AXI_AWLEN)) > SUM_W'(DEPTH - 1));
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    bid_d   = bid_q;
    bresp_d = bresp_q;
    we_c    = 1'b0;
`ifdef AXI_WR_RESP_RANGE_CHECK_EN
    drop_d  = drop_q;
`endif
    case (state_q)
      IDLE: begin
        if (awready_q && AXI_AWVALID) begin
          state_d = DATA;
          ptr_d   = aw_word_c;
          cnt_d   = AXI_AWLEN;
          bid_d   = AXI_AWID;
`ifdef AXI_WR_RESP_RANGE_CHECK_EN
          err_d   = rng_err_c;
          drop_d  = rng_err_c;
`else
          err_d   = 1'b0;
`endif
        end
      end
      DATA: begin
        if (wready_q && AXI_WVALID) begin
`ifdef AXI_WR_RESP_RANGE_CHECK_EN
          we_c  = !drop_q && !AXI_ARESET;
`else
          we_c  = !AXI_ARESET;
`endif
          ptr_d = ptr_q + DEPTH_LOG2'(1);
          cnt_d = cnt_q - 8'd1;
          // AWLEN governs burst length; WLAST only flags a protocol error.
          if (AXI_WLAST != (cnt_q == 8'd0)) err_d = 1'b1;
          if (cnt_q == 8'd0) begin
            state_d = RESP;
            bresp_d = err_d ? RESP_SLVERR : RESP_OKAY;
          end
        end
      end
      RESP: begin
        if (bvalid_q && AXI_BREADY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    awready_d = (state_d == IDLE);
    wready_d  = (state_d == DATA);
    bvalid_d  = (state_d == RESP);
    rdata_d   = mem_q[MEM_RADDR];
  end

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      state_q   <= IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
      ptr_q     <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
`ifdef AXI_WR_RESP_RANGE_CHECK_EN
      drop_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
`ifdef AXI_WR_RESP_RANGE_CHECK_EN
      drop_q    <= drop_d;
`endif
    end
  end

  // Byte-enabled RAM write; contents survive reset.
  always_ff @(posedge AXI_ACLK) begin
    if (we_c) begin
      for (int b = 0; b < int'(BYTES); b++) begin
        if (AXI_WSTRB[b]) mem_q[ptr_q][b*8 +: 8] <= AXI_WDATA[b*8 +: 8];
      end
    end
  end

  assign AXI_AWREADY = awready_q;
  assign AXI_WREADY  = wready_q;
  assign AXI_BVALID  = bvalid_q;
  assign AXI_BID     = bid_q;
  assign AXI_BRESP   = bresp_q;
  assign MEM_RDATA   = rdata_q;

endmodule
